// File: rtl/activation_packer.sv
// Packs one frame of Q4.4 activation bytes little-endian into LANES-byte words behind a
// show-ahead FIFO. Define ACT_PACK_ZCNT_EN to add the per-frame zero_count output.
module activation_packer #(
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   frame_len,
  input  logic [7:0]         act_data,
  input  logic               act_valid,
  output logic [8*LANES-1:0] m_data,
  output logic [LANES-1:0]   m_keep,
  output logic               m_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               busy,
  output logic               done,
  output logic               overflow
`ifdef ACT_PACK_ZCNT_EN
  ,
  output logic [CNT_W-1:0]   zero_count
`endif
);

  localparam int LW = $clog2(LANES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 9*LANES + 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_frame_len;
  logic [CNT_W-1:0]   r_byte_cnt;
  logic [LW-1:0]      r_lane_ptr;
  logic [8*LANES-1:0] r_part;
  logic [EW-1:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_count;
  logic               r_busy;
  logic               r_done;
  logic               r_overflow;

  logic               w_take;
  logic               w_last_byte;
  logic               w_complete;
  logic               w_pop;
  logic               w_full;
  logic               w_drop;
  logic               w_wr;
  logic [8*LANES-1:0] w_word_data;
  logic [LANES-1:0]   w_word_keep;
  logic [EW-1:0]      w_entry;
  logic [EW-1:0]      w_head;

  assign w_take      = (r_state == S_COLLECT) && act_valid;
  assign w_last_byte = w_take && (r_byte_cnt == r_frame_len - CNT_W'(1));
  assign w_complete  = w_take && ((r_lane_ptr == LW'(LANES-1)) || w_last_byte);
  assign w_pop       = (r_count != '0) && m_ready;
  assign w_full      = (r_count == FULL_CNT);
  assign w_drop      = w_complete && w_full && !w_pop;
  assign w_wr        = w_complete && !w_drop;

  // Build the outgoing word from lanes already held plus the incoming byte; higher lanes stay 0
  always_comb begin
    w_word_data = '0;
    w_word_keep = '0;
    for (int k = 0; k < LANES; k++) begin
      if (LW'(k) < r_lane_ptr) begin
        w_word_data[8*k +: 8] = r_part[8*k +: 8];
        w_word_keep[k]        = 1'b1;
      end else if (LW'(k) == r_lane_ptr) begin
        w_word_data[8*k +: 8] = act_data;
        w_word_keep[k]        = 1'b1;
      end
    end
  end

  assign w_entry = {w_last_byte, w_word_keep, w_word_data};

  always_ff @(posedge clk) begin
    if (w_take)
      r_part[{r_lane_ptr, 3'b000} +: 8] <= act_data;
    if (w_wr)
      r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_frame_len <= '0;
      r_byte_cnt  <= '0;
      r_lane_ptr  <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop)
        r_overflow <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_overflow  <= 1'b0;
            r_frame_len <= frame_len;
            r_byte_cnt  <= '0;
            r_lane_ptr  <= '0;
            if (frame_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= S_COLLECT;
              r_busy  <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          if (w_take) begin
            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            if (w_last_byte) begin
              r_lane_ptr <= '0;
              r_state    <= S_DRAIN;
            end else begin
              r_lane_ptr <= r_lane_ptr + LW'(1);
            end
          end
        end
        S_DRAIN: begin
          // The final word was pushed on entry, so an empty FIFO means nothing is pending
          if (r_count == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ACT_PACK_ZCNT_EN
  logic [CNT_W-1:0] r_zero_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_zero_cnt <= '0;
    else if (start && (r_state == S_IDLE))
      r_zero_cnt <= '0;
    else if (w_take && (act_data == 8'h00) && (r_zero_cnt != '1))
      r_zero_cnt <= r_zero_cnt + CNT_W'(1);
  end

  assign zero_count = r_zero_cnt;
`endif

  // Head entry is gated so the word outputs read 0 whenever the FIFO is empty
  assign w_head   = r_mem[r_rd_ptr];
  assign m_valid  = (r_count != '0);
  assign m_data   = m_valid ? w_head[8*LANES-1:0]     : '0;
  assign m_keep   = m_valid ? w_head[9*LANES-1:8*LANES] : '0;
  assign m_last   = m_valid ? w_head[EW-1]            : 1'b0;
  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_overflow;

endmodule
